// File: rtl/eth_mac_tx_10g.sv
// eth_mac_tx_10g: 10G MAC transmit framer turning AXI-stream frames into XGMII 64-bit words.
// Adds /S/+preamble+SFD, CRC32 FCS, /T/ and a fixed idle IFG, advancing only on the PCS clock enable.
module eth_mac_tx_10g #(
  parameter int IFG_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic [63:0] i_axis_tdata,
  input  logic [7:0]  i_axis_tkeep,
  input  logic        i_axis_tvalid,
  input  logic        i_axis_tlast,
  output logic        o_axis_tready,
  output logic [7:0]  o_xgmii_ctrl,
  output logic [63:0] o_xgmii_data,
  output logic        o_frame_done,
  output logic        o_underrun
);

  localparam logic [63:0] IDLE_WORD = {8{8'h07}};
  localparam logic [63:0] ERR_WORD  = {8{8'hFE}};
  localparam logic [63:0] PREAMBLE  = 64'hD5555555555555FB;
  localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
  localparam logic [7:0]  IFG_LAST  = 8'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TAIL, ST_IFG} state_t;

  state_t      state, state_nxt;
  logic [31:0] crc, crc_nxt, crc_beat, fcs;
  logic [31:0] fcs_q, fcs_nxt;
  logic [3:0]  tail_n, tail_n_nxt;
  logic [7:0]  ifg_cnt, ifg_cnt_nxt;
  logic [7:0]  ctrl_q, ctrl_nxt;
  logic [63:0] data_q, data_nxt;
  logic        done_q, done_nxt, unr_q, unr_nxt;
  logic [3:0]  n_valid;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  // Lane content at position p of the trailer stream: 4 FCS bytes, then /T/, then idles.
  function automatic logic [8:0] fcs_lane(input int p, input logic [31:0] f);
    if (p < 4)       return {1'b0, f[8*p +: 8]};
    else if (p == 4) return {1'b1, 8'hFD};
    else             return {1'b1, 8'h07};
  endfunction

  always_comb begin
    crc_beat = crc;
    n_valid  = 4'd0;
    for (int k = 0; k < 8; k++) begin
      if (i_axis_tkeep[k]) begin
        crc_beat = crc_byte(crc_beat, i_axis_tdata[8*k +: 8]);
        n_valid  = n_valid + 4'd1;
      end
    end
  end

  assign fcs = ~crc_beat;

  always_comb begin
    state_nxt   = state;
    crc_nxt     = crc;
    fcs_nxt     = fcs_q;
    tail_n_nxt  = tail_n;
    ifg_cnt_nxt = ifg_cnt;
    ctrl_nxt    = 8'hFF;
    data_nxt    = IDLE_WORD;
    done_nxt    = 1'b0;
    unr_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_axis_tvalid) begin
          ctrl_nxt  = 8'h01;
          data_nxt  = PREAMBLE;
          crc_nxt   = 32'hFFFFFFFF;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!i_axis_tvalid || (!i_axis_tlast && i_axis_tkeep != 8'hFF)) begin
          data_nxt    = ERR_WORD;
          unr_nxt     = 1'b1;
          ifg_cnt_nxt = 8'd0;
          state_nxt   = ST_IFG;
        end else if (!i_axis_tlast) begin
          ctrl_nxt = 8'h00;
          data_nxt = i_axis_tdata;
          crc_nxt  = crc_beat;
        end else begin
          crc_nxt = crc_beat;
          for (int k = 0; k < 8; k++) begin
            if (k < int'(n_valid)) begin
              ctrl_nxt[k]        = 1'b0;
              data_nxt[8*k +: 8] = i_axis_tdata[8*k +: 8];
            end else begin
              {ctrl_nxt[k], data_nxt[8*k +: 8]} = fcs_lane(k - int'(n_valid), fcs);
            end
          end
          // Up to 3 data bytes leave room for the whole FCS and /T/ in this word.
          if (n_valid <= 4'd3) begin
            done_nxt    = 1'b1;
            ifg_cnt_nxt = 8'd0;
            state_nxt   = ST_IFG;
          end else begin
            fcs_nxt    = fcs;
            tail_n_nxt = n_valid;
            state_nxt  = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        for (int k = 0; k < 8; k++)
          {ctrl_nxt[k], data_nxt[8*k +: 8]} = fcs_lane(k + 8 - int'(tail_n), fcs_q);
        done_nxt    = 1'b1;
        ifg_cnt_nxt = 8'd0;
        state_nxt   = ST_IFG;
      end
      ST_IFG: begin
        if (ifg_cnt == IFG_LAST) begin
          ifg_cnt_nxt = 8'd0;
          state_nxt   = ST_IDLE;
        end else begin
          ifg_cnt_nxt = ifg_cnt + 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      crc     <= 32'hFFFFFFFF;
      fcs_q   <= 32'h0;
      tail_n  <= 4'd0;
      ifg_cnt <= 8'd0;
      ctrl_q  <= 8'hFF;
      data_q  <= IDLE_WORD;
      done_q  <= 1'b0;
      unr_q   <= 1'b0;
    end else if (i_clk_en) begin
      state   <= state_nxt;
      crc     <= crc_nxt;
      fcs_q   <= fcs_nxt;
      tail_n  <= tail_n_nxt;
      ifg_cnt <= ifg_cnt_nxt;
      ctrl_q  <= ctrl_nxt;
      data_q  <= data_nxt;
      done_q  <= done_nxt;
      unr_q   <= unr_nxt;
    end
  end

  // Pulse flags hold with the word; gating by the enable shows them in exactly one consumed cycle.
  assign o_axis_tready = (state == ST_DATA) && i_clk_en;
  assign o_xgmii_ctrl  = ctrl_q;
  assign o_xgmii_data  = data_q;
  assign o_frame_done  = done_q && i_clk_en;
  assign o_underrun    = unr_q && i_clk_en;

endmodule

// File: tb/tb_eth_mac_tx_10g.sv
// tb_eth_mac_tx_10g: random AXI frames through eth_mac_tx_10g; every consumed XGMII word is
// checked against a byte-stream framing model with a table-driven CRC32.
`timescale 1ns/1ps
module tb_eth_mac_tx_10g;

  localparam int          IFG_CYCLES = 2;
  localparam logic [63:0] IDLE_W     = {8{8'h07}};

  logic        clk = 1'b0;
  logic        reset, clk_en, tvalid, tlast, tready, frame_done, underrun;
  logic [63:0] tdata, xdata;
  logic [7:0]  tkeep, xctrl;

  eth_mac_tx_10g #(.IFG_CYCLES(IFG_CYCLES)) dut (
    .i_clk(clk), .i_reset(reset), .i_clk_en(clk_en),
    .i_axis_tdata(tdata), .i_axis_tkeep(tkeep), .i_axis_tvalid(tvalid), .i_axis_tlast(tlast),
    .o_axis_tready(tready), .o_xgmii_ctrl(xctrl), .o_xgmii_data(xdata),
    .o_frame_done(frame_done), .o_underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] data;
    logic        done;
    logic        unr;
    logic        b2b;
  } word_t;

  int          tests = 0, fails = 0;
  word_t       exp_q[$];
  logic [31:0] crc_tab[256];
  logic [7:0]  pay[$];
  int          abort_k;
  logic        src_active = 1'b0, dropping = 1'b0, allow_abort = 1'b1;
  logic        first_after_reset = 1'b1, next_b2b = 1'b0;
  int          src_beat = 0, pre_idle = 0, frame_idx = 0, frames_planned = 0;
  int          en_mode = 0, cyc = 0;
  logic        in_frame = 1'b0, hold_valid = 1'b0;
  int          gap = 1000;
  logic [71:0] held;

  function automatic logic [31:0] crc32_ref();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (pay[i]) c = crc_tab[c[7:0] ^ pay[i]] ^ (c >> 8);
    return ~c;
  endfunction

  // Expected word sequence of one frame: preamble, then payload+FCS+/T/ padded with idles, or an abort.
  task automatic model_frame(input int k, input logic b2b);
    word_t w;
    logic [7:0] s[$];
    logic [31:0] f;
    int L;
    L = pay.size();
    w = '{ctrl: 8'h01, data: 64'hD5555555555555FB, done: 1'b0, unr: 1'b0, b2b: b2b};
    exp_q.push_back(w);
    w.b2b = 1'b0;
    if (k >= 0) begin
      for (int b = 0; b < k; b++) begin
        w.ctrl = 8'h00;
        for (int i = 0; i < 8; i++) w.data[8*i +: 8] = pay[8*b+i];
        exp_q.push_back(w);
      end
      w.ctrl = 8'hFF; w.data = {8{8'hFE}}; w.unr = 1'b1;
      exp_q.push_back(w);
    end else begin
      f = crc32_ref();
      s = pay;
      for (int i = 0; i < 4; i++) s.push_back(f[8*i +: 8]);
      s.push_back(8'hFD);
      while (s.size() % 8 != 0) s.push_back(8'h07);
      for (int b = 0; b < s.size() / 8; b++) begin
        w.ctrl = 8'h00; w.done = 1'b0;
        for (int i = 0; i < 8; i++) begin
          w.data[8*i +: 8] = s[8*b+i];
          if (8*b+i >= L+4) w.ctrl[i] = 1'b1;
          if (8*b+i == L+4) w.done = 1'b1;
        end
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic plan_frame(input int idx);
    int len;
    pay.delete();
    abort_k = -1;
    if (idx == 0) begin
      for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    end else begin
      if (idx == 1) len = 64;
      else if (idx == 2) len = 12;
      else if (idx == 3) len = 40;
      else len = int'($urandom_range(60, 130));
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      if (idx == 3) abort_k = 2;
      else if (idx > 3 && allow_abort && $urandom_range(0, 4) == 0)
        abort_k = int'($urandom_range(0, (len + 7) / 8 - 1));
    end
  endtask

  task automatic end_frame();
    src_active = 1'b0;
    pre_idle   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
    next_b2b   = (pre_idle == 0);
  endtask

  task automatic applyStimulus();
    case (en_mode)
      0:       clk_en = 1'b1;
      1:       clk_en = ((cyc % 2) == 0);
      default: clk_en = ($urandom_range(0, 2) != 0);
    endcase
    cyc++;
    if (!src_active && pre_idle == 0 && frame_idx < frames_planned) begin
      plan_frame(frame_idx);
      model_frame(abort_k, next_b2b && !first_after_reset);
      frame_idx++;
      src_active = 1'b1;
      src_beat = 0;
      first_after_reset = 1'b0;
    end
    #1;
    dropping = 1'b0;
    tvalid = 1'b0; tlast = 1'b0; tkeep = 8'h00; tdata = {$urandom, $urandom};
    if (src_active) begin
      if (abort_k >= 0 && src_beat == abort_k && tready) begin
        dropping = 1'b1;
      end else begin
        tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
          if (8*src_beat + i < pay.size()) begin
            tdata[8*i +: 8] = pay[8*src_beat+i];
            tkeep[i] = 1'b1;
          end
        end
        tlast = (8*src_beat + 8 >= pay.size());
      end
    end
  endtask

  task automatic checkOutput();
    word_t e;
    logic is_idle;
    if (!clk_en) begin
      tests++;
      if (tready || frame_done || underrun) begin
        fails++;
        $display("[TB] FAIL hold_ctl tready=%b done=%b unr=%b required 0 0 0", tready, frame_done, underrun);
      end
      if (!hold_valid) begin held = {xctrl, xdata}; hold_valid = 1'b1; end
      return;
    end
    if (hold_valid) begin
      tests++;
      if ({xctrl, xdata} !== held) begin
        fails++;
        $display("[TB] FAIL hold_word got %h required %h", {xctrl, xdata}, held);
      end
      hold_valid = 1'b0;
    end
    is_idle = (xctrl == 8'hFF) && (xdata == IDLE_W) && !frame_done && !underrun;
    if (!in_frame && is_idle) begin gap++; return; end
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL unexpected_word ctrl=%h data=%h required idle", xctrl, xdata);
      return;
    end
    e = exp_q.pop_front();
    if ({xctrl, xdata, frame_done, underrun} !== {e.ctrl, e.data, e.done, e.unr}) begin
      fails++;
      $display("[TB] FAIL word got ctrl=%h data=%h done=%b unr=%b required ctrl=%h data=%h done=%b unr=%b",
               xctrl, xdata, frame_done, underrun, e.ctrl, e.data, e.done, e.unr);
    end
    if (!in_frame) begin
      tests++;
      if (e.b2b ? (gap != IFG_CYCLES) : (gap < IFG_CYCLES)) begin
        fails++;
        $display("[TB] FAIL ifg_gap got %0d idle words required %s%0d", gap, e.b2b ? "" : ">=", IFG_CYCLES);
      end
      in_frame = 1'b1;
    end
    if (e.done || e.unr) begin in_frame = 1'b0; gap = 0; end
  endtask

  task automatic bookkeep();
    if (!clk_en) return;
    if (!src_active && pre_idle > 0) pre_idle--;
    if (dropping) end_frame();
    else if (src_active && tvalid && tready) begin
      if (tlast) end_frame();
      else src_beat++;
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    applyStimulus();
    @(negedge clk);
    checkOutput();
    bookkeep();
  endtask

  task automatic run_frames(input int upto, input int budget);
    int n;
    n = 0;
    frames_planned = upto;
    while ((frame_idx < upto || src_active) && n < budget) begin cycle(); n++; end
    tests++;
    if (n >= budget) begin fails++; $display("[TB] FAIL timeout frames sent %0d required %0d", frame_idx, upto); end
  endtask

  task automatic pin_model();
    word_t w;
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    tests++;
    if (crc32_ref() !== 32'hCBF43926) begin
      fails++; $display("[TB] FAIL model_crc got %h required cbf43926", crc32_ref());
    end
    exp_q.delete(); model_frame(-1, 1'b0);
    w = exp_q[2];
    tests++;
    if (exp_q.size() != 3 || exp_q[1].data !== 64'h3837363534333231 || w.ctrl !== 8'hE0 ||
        w.data !== 64'h0707FDCBF4392639 || !w.done) begin
      fails++; $display("[TB] FAIL model_t1 got ctrl=%h data=%h required ctrl=e0 data=0707fdcbf4392639", w.ctrl, w.data);
    end
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'($urandom));
    exp_q.delete(); model_frame(-1, 1'b0);
    w = exp_q[9];
    tests++;
    if (exp_q.size() != 10 || w.ctrl !== 8'hF0 || w.data[39:32] !== 8'hFD || !w.done || exp_q[8].done) begin
      fails++; $display("[TB] FAIL model_t2 got ctrl=%h lane4=%h required ctrl=f0 lane4=fd", w.ctrl, w.data[39:32]);
    end
    pay.delete();
    for (int i = 0; i < 12; i++) pay.push_back(8'($urandom));
    exp_q.delete(); model_frame(-1, 1'b0);
    w = exp_q[3];
    tests++;
    if (exp_q.size() != 4 || exp_q[2].ctrl !== 8'h00 || w.ctrl !== 8'hFF || w.data !== 64'h07070707070707FD) begin
      fails++; $display("[TB] FAIL model_t3 got ctrl=%h data=%h required ctrl=ff data=07070707070707fd", w.ctrl, w.data);
    end
    exp_q.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
    pin_model();

    reset = 1'b1; clk_en = 1'b1; tvalid = 1'b0; tlast = 1'b0; tkeep = 8'h00; tdata = 64'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (xctrl !== 8'hFF || xdata !== IDLE_W || tready || frame_done || underrun) begin
      fails++;
      $display("[TB] FAIL reset_state got ctrl=%h data=%h tready=%b required ctrl=ff data=%h tready=0", xctrl, xdata, tready, IDLE_W);
    end
    @(posedge clk); #1; reset = 1'b0;

    en_mode = 0; run_frames(4, 3000);
    en_mode = 1; run_frames(8, 6000);
    en_mode = 2; run_frames(24, 20000);
    en_mode = 0; run_frames(30, 10000);

    allow_abort = 1'b0;
    frames_planned = frame_idx + 1;
    n = 0;
    while (!(src_active && src_beat >= 2) && n < 1000) begin cycle(); n++; end
    tests++;
    if (n >= 1000) begin fails++; $display("[TB] FAIL timeout reset_wait beat %0d required 2", src_beat); end
    @(posedge clk); #1; reset = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1; reset = 1'b0; tvalid = 1'b0; tlast = 1'b0; tkeep = 8'h00;
    src_active = 1'b0; pre_idle = 0;
    #1;
    tests++;
    if (xctrl !== 8'hFF || xdata !== IDLE_W || tready || frame_done || underrun) begin
      fails++;
      $display("[TB] FAIL reset_mid got ctrl=%h data=%h tready=%b done=%b unr=%b required idle, tready=0",
               xctrl, xdata, tready, frame_done, underrun);
    end
    exp_q.delete(); in_frame = 1'b0; gap = 1000; hold_valid = 1'b0;
    first_after_reset = 1'b1; next_b2b = 1'b0; allow_abort = 1'b1;

    en_mode = 2; run_frames(frame_idx + 6, 10000);

    n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 400) begin cycle(); n++; end
    tests++;
    if (exp_q.size() != 0 || in_frame) begin
      fails++; $display("[TB] FAIL drain words left %0d required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
